// File: rtl/tx_req_scheduler.sv
// Transmit request scheduler: arbitrates four TLP requesters (P, NP, two CPL
// sources) against per-type header/data flow-control credits and hands one
// granted TLP at a time to the fragmentation buffer.
// Optional feature macro: TX_SCHED_STRICT_PRIO_EN selects fixed priority
// 2 > 3 > 0 > 1 instead of round-robin (default build is round-robin).
module tx_req_scheduler #(
    parameter int unsigned HDR_CRED_W  = 8,
    parameter int unsigned DATA_CRED_W = 12,
    parameter int unsigned LEN_W       = 10
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic [3:0]                 req_valid,
    input  logic [4*LEN_W-1:0]         req_len,
    input  logic                       buf_ready,
    input  logic                       xfer_done,
    input  logic                       fc_upd_valid,
    input  logic [1:0]                 fc_upd_type,
    input  logic [HDR_CRED_W-1:0]      fc_upd_hdr,
    input  logic [DATA_CRED_W-1:0]     fc_upd_data,
    output logic [3:0]                 grant,
    output logic                       busy,
    output logic [3*HDR_CRED_W-1:0]    hdr_cred,
    output logic [3*DATA_CRED_W-1:0]   data_cred
);

    localparam int unsigned NREQ   = 4;
    localparam int unsigned NTYPE  = 3;
    localparam int unsigned COST_W = LEN_W + 1;
    localparam int unsigned DCMP_W = (DATA_CRED_W > COST_W) ? DATA_CRED_W : COST_W;
    localparam int unsigned HSUM_W = HDR_CRED_W + 1;
    localparam int unsigned DSUM_W = DCMP_W + 1;
    localparam logic [HDR_CRED_W-1:0]  HDR_MAX  = '1;
    localparam logic [DATA_CRED_W-1:0] DATA_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // Requester to credit type: both completion sources share the CPL pool.
    function automatic logic [1:0] type_of(input logic [1:0] req);
        return (req == 2'd3) ? 2'd2 : req;
    endfunction

    state_t                  state_q, state_d;
    logic [1:0]              win_q, win_d;
    logic [COST_W-1:0]       cost_q, cost_d;
    logic [3:0]              grant_q, grant_d;
    logic                    busy_q, busy_d;
    logic [HDR_CRED_W-1:0]   hdr_q  [NTYPE];
    logic [HDR_CRED_W-1:0]   hdr_d  [NTYPE];
    logic [DATA_CRED_W-1:0]  data_q [NTYPE];
    logic [DATA_CRED_W-1:0]  data_d [NTYPE];
`ifndef TX_SCHED_STRICT_PRIO_EN
    logic [1:0]              ptr_q, ptr_d;
`endif

    logic [COST_W-1:0]       cost_c [NREQ];
    logic [NREQ-1:0]         elig_c;
    logic                    found_c;
    logic [1:0]              win_c;
    logic [1:0]              idx;
    logic [HSUM_W-1:0]       hsum;
    logic [DSUM_W-1:0]       dsum;

    // Per-requester data cost and eligibility against current credits.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            cost_c[i] = (COST_W'(req_len[i*LEN_W +: LEN_W]) + COST_W'(3)) >> 2;
            elig_c[i] = req_valid[i] && buf_ready
                     && (hdr_q[type_of(2'(i))] != '0)
                     && (DCMP_W'(data_q[type_of(2'(i))]) >= DCMP_W'(cost_c[i]));
        end
    end

    // Winner selection; ineligible requesters are simply skipped.
    always_comb begin
        found_c = 1'b0;
        win_c   = '0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef TX_SCHED_STRICT_PRIO_EN
            // k ^ 2 walks the order 2, 3, 0, 1.
            idx = 2'(k) ^ 2'b10;
`else
            idx = ptr_q + 2'(k);
`endif
            if (!found_c && elig_c[idx]) begin
                found_c = 1'b1;
                win_c   = idx;
            end
        end
    end

    // Next state, winner latch and registered grant/busy.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        cost_d  = cost_q;
`ifndef TX_SCHED_STRICT_PRIO_EN
        ptr_d   = ptr_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (found_c) begin
                    state_d = S_GRANT;
                    win_d   = win_c;
                    cost_d  = cost_c[win_c];
`ifndef TX_SCHED_STRICT_PRIO_EN
                    ptr_d   = win_c + 2'd1;
`endif
                end
            end
            S_GRANT: state_d = S_WAIT;
            S_WAIT:  if (xfer_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        grant_d = (state_d == S_GRANT) ? (4'b0001 << win_d) : 4'b0000;
        busy_d  = (state_d != S_IDLE);
    end

    // Credit counters: returns and the GRANT-cycle debit combine before saturation.
    always_comb begin
        hsum = '0;
        dsum = '0;
        for (int t = 0; t < NTYPE; t++) begin
            hsum = HSUM_W'(hdr_q[t]);
            dsum = DSUM_W'(data_q[t]);
            if (fc_upd_valid && (fc_upd_type == 2'(t))) begin
                hsum = hsum + HSUM_W'(fc_upd_hdr);
                dsum = dsum + DSUM_W'(fc_upd_data);
            end
            if ((state_q == S_GRANT) && (type_of(win_q) == 2'(t))) begin
                hsum = hsum - HSUM_W'(1);
                dsum = dsum - DSUM_W'(cost_q);
            end
            hdr_d[t]  = (hsum > HSUM_W'(HDR_MAX))  ? HDR_MAX  : hsum[HDR_CRED_W-1:0];
            data_d[t] = (dsum > DSUM_W'(DATA_MAX)) ? DATA_MAX : dsum[DATA_CRED_W-1:0];
        end
    end

    // State and datapath registers; reset abandons any transfer in flight.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            cost_q  <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
`ifndef TX_SCHED_STRICT_PRIO_EN
            ptr_q   <= '0;
`endif
            for (int t = 0; t < NTYPE; t++) begin
                hdr_q[t]  <= '0;
                data_q[t] <= '0;
            end
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            cost_q  <= cost_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
`ifndef TX_SCHED_STRICT_PRIO_EN
            ptr_q   <= ptr_d;
`endif
            for (int t = 0; t < NTYPE; t++) begin
                hdr_q[t]  <= hdr_d[t];
                data_q[t] <= data_d[t];
            end
        end
    end

    // Flatten counters onto the output buses, P / NP / CPL from LSB.
    always_comb begin
        for (int t = 0; t < NTYPE; t++) begin
            hdr_cred[t*HDR_CRED_W +: HDR_CRED_W]    = hdr_q[t];
            data_cred[t*DATA_CRED_W +: DATA_CRED_W] = data_q[t];
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_tx_req_scheduler.sv
// Bench for tx_req_scheduler: directed stimulus, grant scoreboard drained by
// an independent monitor, direct checks on credits and busy.
module tb_tx_req_scheduler;

    localparam int unsigned HW = 8;
    localparam int unsigned DW = 12;
    localparam int unsigned LW = 10;

    logic            clk;
    logic            arst;
    logic [3:0]      req_valid;
    logic [4*LW-1:0] req_len;
    logic            buf_ready;
    logic            xfer_done;
    logic            fc_upd_valid;
    logic [1:0]      fc_upd_type;
    logic [HW-1:0]   fc_upd_hdr;
    logic [DW-1:0]   fc_upd_data;
    logic [3:0]      grant;
    logic            busy;
    logic [3*HW-1:0] hdr_cred;
    logic [3*DW-1:0] data_cred;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q [$];

    tx_req_scheduler #(.HDR_CRED_W(HW), .DATA_CRED_W(DW), .LEN_W(LW)) dut (
        .clk(clk), .arst(arst), .req_valid(req_valid), .req_len(req_len),
        .buf_ready(buf_ready), .xfer_done(xfer_done),
        .fc_upd_valid(fc_upd_valid), .fc_upd_type(fc_upd_type),
        .fc_upd_hdr(fc_upd_hdr), .fc_upd_data(fc_upd_data),
        .grant(grant), .busy(busy), .hdr_cred(hdr_cred), .data_cred(data_cred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [HW-1:0] hget(input int t);
        return hdr_cred[t*HW +: HW];
    endfunction

    function automatic logic [DW-1:0] dget(input int t);
        return data_cred[t*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int i, input logic [LW-1:0] v);
        req_len[i*LW +: LW] = v;
    endtask

    task automatic fc(input logic [1:0] t, input logic [HW-1:0] h, input logic [DW-1:0] d);
        fc_upd_valid = 1'b1;
        fc_upd_type  = t;
        fc_upd_hdr   = h;
        fc_upd_data  = d;
        tick();
        fc_upd_valid = 1'b0;
        fc_upd_hdr   = '0;
        fc_upd_data  = '0;
    endtask

    // Wait for a grant, finish the transfer, confirm a return to idle.
    task automatic serve();
        int n = 0;
        while (busy !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("serve_grant_seen", busy, 1);
        if (busy === 1'b1) begin
            tick();
            xfer_done = 1'b1;
            tick();
            xfer_done = 1'b0;
            check("serve_idle_gap", busy, 0);
        end
    endtask

    task automatic do_reset();
        arst         = 1'b1;
        req_valid    = '0;
        req_len      = '0;
        buf_ready    = 1'b1;
        xfer_done    = 1'b0;
        fc_upd_valid = 1'b0;
        tick();
        tick();
        arst = 1'b0;
        tick();
    endtask

    // Monitor: every grant pulse is matched against the scoreboard.
    initial begin
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (grant !== 4'b0000) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", grant, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("grant", grant, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        arst = 1'b1; req_valid = '0; req_len = '0; buf_ready = 1'b1;
        xfer_done = 1'b0; fc_upd_valid = 1'b0; fc_upd_type = '0;
        fc_upd_hdr = '0; fc_upd_data = '0;
        tick();
        tick();
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_hdr", hdr_cred, 0);
        check("rst_data", data_cred, 0);
        arst = 1'b0;
        tick();

        // Credit update then single P grant with 16 DW payload.
        fc(2'd0, 8'd2, 12'd8);
        check("p_hdr_loaded", hget(0), 2);
        check("p_data_loaded", dget(0), 8);
        set_len(0, 10'd16);
        req_valid = 4'b0001;
        exp_q.push_back(4'b0001);
        tick();
        check("busy_in_grant", busy, 1);
        req_valid = 4'b0000;
        tick();
        check("p_hdr_debit", hget(0), 1);
        check("p_data_debit", dget(0), 4);
        tick();
        tick();
        check("busy_in_wait", busy, 1);
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        check("busy_after_done", busy, 0);
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        tick();
        check("stray_done_idle", busy, 0);

        // Round-robin across all four, then back-to-back single requester.
        do_reset();
        fc(2'd0, 8'd20, 12'd40);
        fc(2'd1, 8'd20, 12'd40);
        fc(2'd2, 8'd20, 12'd40);
        for (int i = 0; i < 4; i++) set_len(i, 10'd4);
        req_valid = 4'b1111;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        for (int i = 0; i < 5; i++) serve();
        req_valid = 4'b0000;
        tick();
        check("rr_p_hdr", hget(0), 18);
        check("rr_cpl_hdr", hget(2), 18);
        check("rr_np_data", dget(1), 39);
        req_valid = 4'b0001;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0001);
        serve();
        serve();
        req_valid = 4'b0000;
        tick();
        check("b2b_p_hdr", hget(0), 16);

        // NP starved of header credit must not block CPL.
        do_reset();
        fc(2'd1, 8'd0, 12'd10);
        fc(2'd2, 8'd3, 12'd10);
        set_len(1, 10'd4);
        set_len(2, 10'd4);
        req_valid = 4'b0110;
        exp_q.push_back(4'b0100);
        serve();
        req_valid = 4'b0010;
        repeat (5) tick();
        check("np_starved_idle", busy, 0);
        check("cpl_hdr_after", hget(2), 2);
        exp_q.push_back(4'b0010);
        fc(2'd1, 8'd1, 12'd0);
        serve();
        req_valid = 4'b0000;
        tick();
        check("np_hdr_after", hget(1), 0);
        check("np_data_after", dget(1), 9);

        // Same-cycle CPL return and debit: 4 + 10 - 4.
        do_reset();
        fc(2'd2, 8'd5, 12'd4);
        set_len(2, 10'd16);
        req_valid = 4'b0100;
        exp_q.push_back(4'b0100);
        tick();
        req_valid = 4'b0000;
        fc(2'd2, 8'd0, 12'd10);
        check("cpl_data_merge", dget(2), 10);
        check("cpl_hdr_merge", hget(2), 4);
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;

        // Saturation, buf_ready gating, cost rounding, zero-length payload.
        do_reset();
        fc(2'd0, 8'hFF, 12'd0);
        fc(2'd0, 8'hFF, 12'd100);
        check("hdr_saturate", hget(0), 8'hFF);
        fc(2'd1, 8'd0, 12'hFFF);
        fc(2'd1, 8'd0, 12'hFFF);
        check("data_saturate", dget(1), 12'hFFF);
        buf_ready = 1'b0;
        set_len(0, 10'd5);
        req_valid = 4'b0001;
        repeat (5) tick();
        check("buf_not_ready", busy, 0);
        exp_q.push_back(4'b0001);
        buf_ready = 1'b1;
        serve();
        req_valid = 4'b0000;
        tick();
        check("cost_round_up", dget(0), 98);
        check("sat_hdr_debit", hget(0), 8'hFE);
        fc(2'd2, 8'd1, 12'd0);
        set_len(3, 10'd0);
        req_valid = 4'b1000;
        exp_q.push_back(4'b1000);
        serve();
        req_valid = 4'b0000;
        tick();
        check("zero_len_hdr", hget(2), 0);
        check("zero_len_data", dget(2), 0);

        // Reset during WAIT abandons the transfer and its credits.
        do_reset();
        fc(2'd0, 8'd2, 12'd8);
        set_len(0, 10'd16);
        req_valid = 4'b0001;
        exp_q.push_back(4'b0001);
        tick();
        tick();
        check("pre_reset_wait", busy, 1);
        arst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_grant", grant, 0);
        check("mid_rst_hdr", hdr_cred, 0);
        check("mid_rst_data", data_cred, 0);
        tick();
        tick();
        arst = 1'b0;
        repeat (5) tick();
        check("post_rst_idle", busy, 0);
        set_len(0, 10'd4);
        exp_q.push_back(4'b0001);
        fc(2'd0, 8'd1, 12'd1);
        serve();
        req_valid = 4'b0000;
        repeat (3) tick();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tx_req_scheduler.md
TX_REQ_SCHEDULER -- requirements
Module: tx_req_scheduler

Interface
REQ-001 Parameters:
- HDR_CRED_W, default 8, header-credit counter width.
- DATA_CRED_W, default 12, data-credit counter width.
- LEN_W, default 10, TLP payload length field width in DW.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock; all logic on rising edge.
- arst, in, 1, asynchronous active-high reset.
- req_valid, in, 4, per-requester request: [0] AXI slave write (P), [1] AXI slave read (NP), [2] AXI master completion (CPL), [3] Rx router completion (CPL).
- req_len, in, 4*LEN_W, payload length in DW per requester, slice i = [i*LEN_W +: LEN_W]; 0 = no payload.
- buf_ready, in, 1, fragmentation buffer can accept a TLP.
- xfer_done, in, 1, single-cycle pulse when the granted TLP is fully written to the buffer.
- fc_upd_valid, in, 1, DLL credit-return strobe.
- fc_upd_type, in, 2, credit type: 0=P, 1=NP, 2=CPL, 3=ignored.
- fc_upd_hdr, in, HDR_CRED_W, header credits returned.
- fc_upd_data, in, DATA_CRED_W, data credits returned.
- grant, out, 4, one-hot grant pulse.
- busy, out, 1, high from grant cycle until xfer_done.
- hdr_cred, out, 3*HDR_CRED_W, current header credits, P/NP/CPL.
- data_cred, out, 3*DATA_CRED_W, current data credits, P/NP/CPL.

Function
REQ-003 Requesters map to credit types as follows: 0 uses P, 1 uses NP, 2 and 3 use CPL.
REQ-004 Data-credit cost SHALL be ceil(req_len/4), computed as (req_len+3)>>2 in LEN_W+1 bits; header cost SHALL be 1.
REQ-005 Requester i is eligible when req_valid[i]=1, the header credit for its type is >=1, the data credit for its type is >=cost, and buf_ready=1.
REQ-006 The FSM SHALL have three states:
- IDLE: go to GRANT if any requester is eligible.
- GRANT: exactly one cycle; assert grant[winner]; go to WAIT.
- WAIT: return to IDLE on xfer_done.
REQ-007 The winner SHALL be latched when leaving IDLE; grant SHALL be registered, one-hot, and high for exactly one cycle, appearing 1 cycle after eligibility.
REQ-008 Credits SHALL be debited in the GRANT cycle using the cost latched with the winner.
REQ-009 busy SHALL be 1 in GRANT and WAIT, 0 in IDLE.
REQ-010 Arbitration SHALL be round-robin (default build): the pointer advances to winner+1 mod 4 on each grant, and search starts at the pointer.
REQ-011 A requester whose request is ineligible for lack of credit SHALL NOT block others (no head-of-line blocking across types).
REQ-012 fc_upd_valid SHALL add fc_upd_hdr/fc_upd_data to the selected type's counters, saturating at the all-ones value.
REQ-013 A credit update and a debit of the same type in the same cycle SHALL both apply: next = cur + upd - cost, with saturation applied after the sum.
REQ-014 xfer_done outside WAIT SHALL be ignored.
REQ-015 req_valid deasserting after the winner is latched SHALL NOT cancel the grant.
REQ-016 A requester holding req_valid high with no eligible competitor MAY be granted back-to-back, with at least 1 IDLE cycle between grants.

Reset
REQ-017 While arst=1 (asynchronous), the block SHALL hold:
- FSM in IDLE, grant=0, busy=0.
- RR pointer=0, latched winner/cost=0.
- All credit counters=0.
REQ-018 arst asserted mid-transfer SHALL abandon the transfer without restoring credits; operation resumes from IDLE on the first clock after release.

Configuration
REQ-019 With `TX_SCHED_STRICT_PRIO_EN` defined, arbitration SHALL be fixed priority 2 > 3 > 0 > 1 (completions first), and the RR pointer SHALL be absent.
REQ-020 Without `TX_SCHED_STRICT_PRIO_EN` defined, arbitration SHALL be round-robin per REQ-010.

Verification
REQ-021 Credit update and single grant: after reset, return P hdr=2, data=8; then req_valid=0001 with req_len=16:
- grant=0001 one cycle later.
- P data credit drops 8->4; P hdr credit drops 2->1.
REQ-022 Round-robin fairness: all four valid with ample credits; pulse xfer_done after each grant -> grants in order 0001, 0010, 0100, 1000, 0001 (default build).
REQ-023 Credit starvation bypass: NP hdr=0 and CCL hdr=3; req_valid=0110 -> grant=0100 only; req1 is never granted until NP credit is returned.
REQ-024 Simultaneous update and debit: CPL data=4 at grant of req_len=16 while the same cycle returns CPL data=10 -> CPL data=10 the next cycle.
REQ-025 Saturation and boundary cases:
- Return 0xFF header credits twice -> counter holds 0xFF.
- buf_ready=0 -> no grant for any request.
REQ-026 Reset mid-operation: assert arst in WAIT -> busy=0 and credits=0 immediately; no spurious grant after release.
